rotary_quad_decoder: RTL and testbench

//  Decodes a mechanical quadrature rotary encoder into an 8-bit up/down value.
//  The value feeds binary2bcd.bin directly, which drives the BCD display path.
//  Raw A/B pins are synchronised and debounced, then tracked by a Gray-phase FSM.

---
 rtl/rotary_quad_decoder.sv | 172 +++++++++++++++++
 tb/tb_rotary_quad_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rotary_quad_decoder.sv
// rtl/rotary_quad_decoder.sv - quadrature rotary encoder to 8-bit up/down count with step pulses
module rotary_quad_decoder #(
    parameter int DEBOUNCE_CYCLES  = 1000,
    parameter int STEPS_PER_DETENT = 4,
    parameter int COUNT_MAX        = 255,
    parameter int WRAP             = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       quad_a,
    input  logic       quad_b,
    input  logic       clear,
    output logic [7:0] value,
    output logic       step_up,
    output logic       step_dn,
    output logic       quad_err,
    output logic       ready
);

    localparam int                DBW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0]    DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [3:0] S_POS   = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0] S_NEG   = -S_POS;
    localparam logic [7:0]        VMAX    = 8'(COUNT_MAX);

    typedef enum logic {INIT, TRACK} state_t;

    state_t                 state;
    logic [1:0]             meta;       // phase bits are packed as {A, B}
    logic [1:0]             sync;
    logic [1:0]             filt;
    logic [1:0]             prev_phase;
    logic [1:0]             stab_ref;
    logic [1:0][DBW-1:0]    db_cnt;
    logic [DBW-1:0]         stab_cnt;
    logic signed [3:0]      acc;

    logic [1:0]             cw_next;
    logic [1:0]             ccw_next;
    logic                   moved;
    logic                   is_cw;
    logic                   is_ccw;
    logic                   is_err;
    logic signed [3:0]      acc_step;
    logic                   det_up;
    logic                   det_dn;

    // CW walks 00->10->11->01->00; CCW is the reverse walk
    always_comb begin
        cw_next  = 2'b00;
        ccw_next = 2'b00;
        case (prev_phase)
            2'b00: begin cw_next = 2'b10; ccw_next = 2'b01; end
            2'b10: begin cw_next = 2'b11; ccw_next = 2'b00; end
            2'b11: begin cw_next = 2'b01; ccw_next = 2'b10; end
            default: begin cw_next = 2'b00; ccw_next = 2'b11; end
        endcase
        moved  = (filt != prev_phase);
        is_cw  = moved && (filt == cw_next);
        is_ccw = moved && (filt == ccw_next);
        is_err = moved && !is_cw && !is_ccw;
        if (is_cw)
            acc_step = acc + 4'sd1;
        else if (is_ccw)
            acc_step = acc - 4'sd1;
        else
            acc_step = acc;
        det_up = is_cw && (acc_step == S_POS);
        det_dn = is_ccw && (acc_step == S_NEG);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            meta       <= 2'b00;
            sync       <= 2'b00;
            filt       <= 2'b00;
            prev_phase <= 2'b00;
            stab_ref   <= 2'b00;
            db_cnt     <= '0;
            stab_cnt   <= '0;
            acc        <= '0;
            value      <= 8'd0;
            step_up    <= 1'b0;
            step_dn    <= 1'b0;
            quad_err   <= 1'b0;
            ready      <= 1'b0;
        end else begin
            meta     <= {quad_a, quad_b};
            sync     <= meta;
            step_up  <= 1'b0;
            step_dn  <= 1'b0;
            quad_err <= 1'b0;

            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end

            case (state)
                INIT: begin
                    ready <= 1'b0;
                    if (sync != stab_ref) begin
                        stab_ref <= sync;
                        stab_cnt <= '0;
                    end else if (stab_cnt == DB_LAST) begin
                        // Seed the tracker from the settled pins so start-up reports no motion
                        state      <= TRACK;
                        ready      <= 1'b1;
                        filt       <= sync;
                        prev_phase <= sync;
                        db_cnt     <= '0;
                        stab_cnt   <= '0;
                        acc        <= '0;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                default: begin
                    ready <= 1'b1;
                    if (moved)
                        prev_phase <= filt;
                    if (is_err) begin
                        quad_err <= 1'b1;
                        acc      <= '0;
                    end else if (det_up || det_dn) begin
                        acc <= '0;
                    end else begin
                        acc <= acc_step;
                    end
                    if (det_up) begin
                        if (value == VMAX) begin
                            if (WRAP != 0) begin
                                value   <= 8'd0;
                                step_up <= 1'b1;
                            end
                        end else begin
                            value   <= value + 8'd1;
                            step_up <= 1'b1;
                        end
                    end
                    if (det_dn) begin
                        if (value == 8'd0) begin
                            if (WRAP != 0) begin
                                value   <= VMAX;
                                step_dn <= 1'b1;
                            end
                        end else begin
                            value   <= value - 8'd1;
                            step_dn <= 1'b1;
                        end
                    end
                end
            endcase

            // clear overrides any detent landing in the same cycle; quad_err is left alone
            if (clear) begin
                value   <= 8'd0;
                acc     <= '0;
                step_up <= 1'b0;
                step_dn <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// tb/tb_rotary_quad_decoder.sv - directed table-driven bench for rotary_quad_decoder
module tb_rotary_quad_decoder;

    logic       clk;
    logic       reset;
    logic       qa;
    logic       qb;
    logic       clear;
    logic [7:0] v1, v2;
    logic       up1, dn1, err1, rdy1;
    logic       up2, dn2, err2, rdy2;

    int checks = 0;
    int errors = 0;
    int n_up1, n_dn1, n_err1, n_up2, n_dn2, n_err2;
    int lat_up1;

    typedef struct {
        logic a;
        logic b;
        int   hold;
        int   v1;
        int   v2;
        int   up1;
        int   dn1;
        int   up2;
        int   dn2;
        int   err;
    } vec_t;

    vec_t vecs[19];

    rotary_quad_decoder #(.DEBOUNCE_CYCLES(4), .STEPS_PER_DETENT(4), .COUNT_MAX(255), .WRAP(1)) dut_w (
        .clk(clk), .reset(reset), .quad_a(qa), .quad_b(qb), .clear(clear),
        .value(v1), .step_up(up1), .step_dn(dn1), .quad_err(err1), .ready(rdy1)
    );

    rotary_quad_decoder #(.DEBOUNCE_CYCLES(4), .STEPS_PER_DETENT(4), .COUNT_MAX(255), .WRAP(0)) dut_s (
        .clk(clk), .reset(reset), .quad_a(qa), .quad_b(qb), .clear(clear),
        .value(v2), .step_up(up2), .step_dn(dn2), .quad_err(err2), .ready(rdy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic zero_counts();
        n_up1 = 0; n_dn1 = 0; n_err1 = 0;
        n_up2 = 0; n_dn2 = 0; n_err2 = 0;
        lat_up1 = -1;
    endtask

    task automatic tick_count(input int k);
        @(negedge clk);
        if (up1) begin n_up1++; lat_up1 = k; end
        if (dn1) n_dn1++;
        if (err1) n_err1++;
        if (up2) n_up2++;
        if (dn2) n_dn2++;
        if (err2) n_err2++;
    endtask

    task automatic apply(input logic a, input logic b, input int hold);
        qa = a;
        qb = b;
        zero_counts();
        for (int k = 1; k <= hold; k++)
            tick_count(k);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].hold);
            check($sformatf("v%0d value_wrap", i), int'(v1), vecs[i].v1);
            check($sformatf("v%0d value_sat", i), int'(v2), vecs[i].v2);
            check($sformatf("v%0d up_wrap", i), n_up1, vecs[i].up1);
            check($sformatf("v%0d dn_wrap", i), n_dn1, vecs[i].dn1);
            check($sformatf("v%0d up_sat", i), n_up2, vecs[i].up2);
            check($sformatf("v%0d dn_sat", i), n_dn2, vecs[i].dn2);
            check($sformatf("v%0d err_wrap", i), n_err1, vecs[i].err);
            check($sformatf("v%0d err_sat", i), n_err2, vecs[i].err);
        end
    endtask

    initial begin
        // a, b, hold, v_wrap, v_sat, up_w, dn_w, up_s, dn_s, err
        vecs[0]  = '{1'b1, 1'b0, 8,   0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1'b1, 1'b1, 8,   0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1'b0, 1'b1, 8,   0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 8,   1, 1, 1, 0, 1, 0, 0};
        vecs[4]  = '{1'b0, 1'b1, 8,   1, 1, 0, 0, 0, 0, 0};
        vecs[5]  = '{1'b1, 1'b1, 8,   1, 1, 0, 0, 0, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 8,   1, 1, 0, 0, 0, 0, 0};
        vecs[7]  = '{1'b0, 1'b0, 8,   0, 0, 0, 1, 0, 1, 0};
        vecs[8]  = '{1'b0, 1'b1, 8,   0, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{1'b1, 1'b1, 8,   0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{1'b1, 1'b0, 8,   0, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{1'b0, 1'b0, 8, 255, 0, 0, 1, 0, 0, 0};
        vecs[12] = '{1'b1, 1'b0, 8, 255, 0, 0, 0, 0, 0, 0};
        vecs[13] = '{1'b1, 1'b1, 8, 255, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{1'b0, 1'b0, 8, 255, 0, 0, 0, 0, 0, 1};
        vecs[15] = '{1'b1, 1'b0, 8, 255, 0, 0, 0, 0, 0, 0};
        vecs[16] = '{1'b1, 1'b1, 8, 255, 0, 0, 0, 0, 0, 0};
        vecs[17] = '{1'b0, 1'b1, 8, 255, 0, 0, 0, 0, 0, 0};
        vecs[18] = '{1'b0, 1'b0, 8,   0, 1, 1, 0, 1, 0, 0};

        // Reset with pins resting at 11
        qa = 1'b1; qb = 1'b1; clear = 1'b0; reset = 1'b1;
        zero_counts();
        repeat (3) @(negedge clk);
        check("reset value", int'(v1), 0);
        check("reset ready", int'(rdy1), 0);
        check("reset pulses", int'(up1) + int'(dn1) + int'(err1), 0);
        reset = 1'b0;
        apply(1'b1, 1'b1, 10);
        check("init ready_wrap", int'(rdy1), 1);
        check("init ready_sat", int'(rdy2), 1);
        check("init value", int'(v1), 0);
        check("init pulses", n_up1 + n_dn1 + n_err1 + n_up2 + n_dn2 + n_err2, 0);

        // Re-seed from rest 00 for the rotation table
        @(negedge clk);
        reset = 1'b1;
        qa = 1'b0; qb = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        apply(1'b0, 1'b0, 10);
        check("rest ready", int'(rdy1), 1);

        run_range(0, 3);
        check("cw latency from raw edge", lat_up1, 7);
        run_range(4, 11);

        // Sub-debounce glitches on A must never reach the tracker
        zero_counts();
        for (int g = 0; g < 10; g++) begin
            qa = 1'b1;
            for (int k = 0; k < 3; k++) tick_count(0);
            qa = 1'b0;
            for (int k = 0; k < 3; k++) tick_count(0);
        end
        repeat (8) tick_count(0);
        check("glitch value_wrap", int'(v1), 255);
        check("glitch value_sat", int'(v2), 0);
        check("glitch pulses", n_up1 + n_dn1 + n_err1 + n_up2 + n_dn2 + n_err2, 0);

        run_range(12, 18);

        // clear lands on the detent-completion cycle
        apply(1'b1, 1'b0, 8);
        apply(1'b1, 1'b1, 8);
        apply(1'b0, 1'b1, 8);
        qa = 1'b0; qb = 1'b0;
        zero_counts();
        for (int k = 1; k <= 8; k++) begin
            tick_count(k);
            if (k == 7) begin
                check("clear cycle value_sat", int'(v2), 0);
                clear = 1'b0;
            end else if (k == 6) begin
                clear = 1'b1;
            end
        end
        check("clear up_wrap", n_up1, 0);
        check("clear up_sat", n_up2, 0);
        check("clear value_wrap", int'(v1), 0);
        check("clear value_sat", int'(v2), 0);

        // Reset mid-detent discards the partial accumulation
        apply(1'b1, 1'b0, 8);
        apply(1'b1, 1'b1, 8);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset value", int'(v1), 0);
        check("midreset ready", int'(rdy1), 0);
        reset = 1'b0;
        apply(1'b1, 1'b1, 1);
        check("midreset still init", int'(rdy1), 0);
        apply(1'b1, 1'b1, 10);
        check("midreset recovered", int'(rdy1), 1);
        apply(1'b0, 1'b1, 8);
        apply(1'b0, 1'b0, 8);
        check("midreset no early detent", int'(v1), 0);
        check("midreset no early up", n_up1, 0);
        apply(1'b1, 1'b0, 8);
        apply(1'b1, 1'b1, 8);
        check("midreset detent value_wrap", int'(v1), 1);
        check("midreset detent up_wrap", n_up1, 1);
        check("midreset detent value_sat", int'(v2), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
